// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioning block: per-channel
// state encoding, default timing constants and the counter-width helper.
package key_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DB_PRESS = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] DB_REL   = 2'd3;

  // 20 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
  localparam int         DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int         DEF_REPEAT_DLY   = 25_000_000;
  localparam int         DEF_REPEAT_PER   = 5_000_000;
  localparam logic [2:0] DEF_REPEAT_EN    = 3'b011;

  // One counter serves both debounce and repeat timing, so it is sized for
  // the larger of the two terminal counts, with a spare bit of headroom.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/key_chan.sv
// One push-button channel: 2-flop synchroniser, press/release debounce
// state machine with optional auto-repeat, and a registered one-cycle pulse.
module key_chan
  import key_pkg::*;
#(
  parameter int   DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int   REPEAT_DLY   = DEF_REPEAT_DLY,
  parameter int   REPEAT_PER   = DEF_REPEAT_PER,
  parameter logic RPT          = 1'b0
) (
  input  logic clk50M,
  input  logic rst_n,
  input  logic key_n,
  output logic flg
);

  localparam int CW = cnt_width(DEBOUNCE_CYC, REPEAT_DLY);

  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] RPT_LAST   = CW'(REPEAT_DLY - 1);
  // Reloading here instead of zero makes every later repeat REPEAT_PER apart
  // while reusing the same terminal compare as the first repeat.
  localparam logic [CW-1:0] RPT_RELOAD = CW'(REPEAT_DLY - REPEAT_PER);

  logic          sync_p0;
  logic          sync_p1;
  logic          pressed;
  logic [1:0]    state;
  logic [CW-1:0] cnt;

  // Synchronise the asynchronous button; resets to the released level
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed = ~sync_p1;

  // Debounce/repeat state machine; flg is high only on the cycle after a pulse event
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      flg   <= 1'b0;
    end else begin
      flg <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pressed) begin
            state <= DB_PRESS;
          end
        end
        DB_PRESS: begin
          if (!pressed) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            flg   <= 1'b1;
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (!pressed) begin
            state <= DB_REL;
            cnt   <= '0;
          end else if (!RPT) begin
            cnt <= '0;
          end else if (cnt == RPT_LAST) begin
            flg <= 1'b1;
            cnt <= RPT_RELOAD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DB_REL: begin
          // A bounce back to pressed re-enters HELD silently and restarts repeat timing
          if (pressed) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_pulse.sv
// Three independent key channels turning raw active-low buttons into the
// game FSM's single-cycle command pulses flg1 (right), flg2 (left), flg3 (colour).
module key_pulse
  import key_pkg::*;
#(
  parameter int         DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int         REPEAT_DLY   = DEF_REPEAT_DLY,
  parameter int         REPEAT_PER   = DEF_REPEAT_PER,
  parameter logic [2:0] REPEAT_EN    = DEF_REPEAT_EN
) (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic [2:0] key_n,
  output logic       flg1,
  output logic       flg2,
  output logic       flg3
);

  logic [2:0] flg;

  for (genvar i = 0; i < 3; i++) begin : g_chan
    key_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DLY   (REPEAT_DLY),
      .REPEAT_PER   (REPEAT_PER),
      .RPT          (REPEAT_EN[i])
    ) u_chan (
      .clk50M (clk50M),
      .rst_n  (rst_n),
      .key_n  (key_n[i]),
      .flg    (flg[i])
    );
  end

  // No arbitration: simultaneous pulses pass straight through
  assign flg1 = flg[0];
  assign flg2 = flg[1];
  assign flg3 = flg[2];

endmodule

// File: tb/tb_key_pulse.sv
// Scoreboard bench for key_pulse: expected pulse edges are derived from the
// documented latencies when a key is driven and matched as pulses appear.
module tb_key_pulse;

  localparam int DB  = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic       clk50M = 1'b0;
  logic       rst_n;
  logic [2:0] key_n;
  logic       flg1;
  logic       flg2;
  logic       flg3;

  typedef struct {
    int         cyc;
    logic [2:0] flg;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  always #10 clk50M = ~clk50M;

  always @(posedge clk50M) edge_cnt <= edge_cnt + 1;

  key_pulse #(
    .DEBOUNCE_CYC (DB),
    .REPEAT_DLY   (DLY),
    .REPEAT_PER   (PER),
    .REPEAT_EN    (3'b011)
  ) dut (
    .clk50M (clk50M),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .flg1   (flg1),
    .flg2   (flg2),
    .flg3   (flg3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Every pulse seen is matched against the oldest outstanding expectation
  always @(negedge clk50M) begin
    logic [2:0] f;
    exp_t       e;
    f = {flg3, flg2, flg1};
    if (f !== 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(f), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_edge", edge_cnt, e.cyc);
        check("pulse_flags", 32'(f), 32'(e.flg));
      end
    end
  end

  // Key low first sampled at edge e0 and held for hold edges: press pulse at
  // e0+DB+2, repeats DLY then every PER later, while the held level is still seen.
  task automatic push_press(input logic [2:0] fl, input int e0, input int hold, input bit rpt);
    int t;
    int last;
    t    = e0 + DB + 2;
    last = e0 + hold + 1;
    if (t <= last) begin
      exp_q.push_back('{t, fl});
      if (rpt) begin
        t += DLY;
        while (t <= last) begin
          exp_q.push_back('{t, fl});
          t += PER;
        end
      end
    end
  endtask

  task automatic press(input logic [2:0] mask, input int hold, input bit rpt);
    push_press(mask, edge_cnt + 1, hold, rpt);
    key_n = key_n & ~mask;
    repeat (hold) @(negedge clk50M);
    key_n = key_n | mask;
  endtask

  task automatic settle(input int n, input string tag);
    repeat (n) @(negedge clk50M);
    check({"missing_pulses_", tag}, exp_q.size(), 0);
  endtask

  initial begin
    int e0;
    rst_n = 1'b0;
    key_n = 3'b111;
    repeat (3) @(negedge clk50M);
    check("reset_flags", {29'd0, flg3, flg2, flg1}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk50M);

    // clean press, then a new press as soon as the channel should be idle again
    press(3'b001, 6, 1'b1);
    repeat (6) @(negedge clk50M);
    press(3'b001, 6, 1'b1);
    settle(12, "clean");

    // glitch on key 1, then a normal press proving the channel went idle
    press(3'b010, 3, 1'b1);
    settle(10, "glitch");
    press(3'b010, 6, 1'b1);
    settle(12, "after_glitch");

    // held key 0: press pulse plus auto-repeat cadence
    press(3'b001, 40, 1'b1);
    settle(12, "repeat");

    // held key 2 without repeat, then a release bounce
    press(3'b100, 40, 1'b0);
    repeat (2) @(negedge clk50M);
    key_n[2] = 1'b0;
    repeat (10) @(negedge clk50M);
    key_n[2] = 1'b1;
    settle(12, "no_repeat_bounce");

    // simultaneous keys 0 and 1
    press(3'b011, 6, 1'b1);
    settle(12, "simultaneous");

    // reset mid-repeat with key 0 held through it
    e0 = edge_cnt + 1;
    exp_q.push_back('{e0 + 6, 3'b001});
    exp_q.push_back('{e0 + 16, 3'b001});
    exp_q.push_back('{e0 + 19, 3'b001});
    key_n[0] = 1'b0;
    repeat (21) @(negedge clk50M);
    check("pre_reset_queue", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("flags_at_reset", {29'd0, flg3, flg2, flg1}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk50M);
      check("flags_in_reset", {29'd0, flg3, flg2, flg1}, 0);
    end
    rst_n = 1'b1;
    push_press(3'b001, edge_cnt + 1, 30, 1'b1);
    repeat (30) @(negedge clk50M);
    key_n[0] = 1'b1;
    settle(12, "reset_held");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_pulse.md
# key_pulse

Conditions the three raw push-button inputs of the ball game into clean single-cycle command pulses `flg1` (board right), `flg2` (board left) and `flg3` (colour step) for the game FSM. Each key is synchronised, debounced on press and release, and optionally auto-repeated while held, so a held move key keeps the board stepping. It sits directly upstream of the game FSM; its outputs drive the FSM's `flg1`/`flg2`/`flg3` inputs with no further logic.

## Interface
- `DEBOUNCE_CYC`, 1_000_000: stable-level cycles required to accept a press or release (20 ms at 50 MHz); ≥2.
- `REPEAT_DLY`, 25_000_000: cycles from the accepted-press pulse to the first repeat pulse; ≥2.
- `REPEAT_PER`, 5_000_000: cycles between later repeat pulses; 2 ≤ `REPEAT_PER` ≤ `REPEAT_DLY`.
- `REPEAT_EN`, 3'b011: bit i enables auto-repeat for key i; the default is repeat on `flg1`/`flg2` only.
- `clk50M`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_n`  in  3  raw buttons, active-low, asynchronous to `clk50M`; bit 0→`flg1`, bit 1→`flg2`, bit 2→`flg3`.
- `flg1`  out  1  one-cycle pulse, key 0 press or repeat.
- `flg2`  out  1  one-cycle pulse, key 1 press or repeat.
- `flg3`  out  1  one-cycle pulse, key 2 press or repeat.

## Operation
- There are three identical, fully independent channels. No arbitration: `flg1` and `flg2` may pulse in the same cycle. The downstream FSM gives `flg1` priority.
- Each channel has a 2-flop synchroniser with reset value 1 (released). The synchroniser output is `p` = pressed when low.
- Per-channel state machine. `cnt` is an unsigned counter of width `$clog2(max(DEBOUNCE_CYC,REPEAT_DLY))+1`, cleared on every state change unless stated otherwise.
  - IDLE: if `p`, go to DB_PRESS.
  - DB_PRESS: if `!p`, go to IDLE with no pulse (glitch rejected). Else, if `cnt==DEBOUNCE_CYC-1`, assert the flag for one cycle and go to HELD. Else increment `cnt`.
  - HELD: if `!p`, go to DB_REL. Else, if the repeat bit is 0, hold `cnt`=0. Else increment `cnt`. When `cnt==REPEAT_DLY-1`, pulse and load `cnt`←`REPEAT_DLY-REPEAT_PER`.
  - DB_REL: if `p`, return to HELD with no pulse and `cnt`=0 (release bounce rejected; repeat timing restarts). Else, if `cnt==DEBOUNCE_CYC-1`, go to IDLE. Else increment `cnt`.
- Only DB_PRESS→HELD and the HELD repeat event produce pulses. A pulse never lasts more than 1 cycle.
- Reset, including mid-operation: all channels go to IDLE, `cnt`=0, synchronisers=1, all flags=0. A key held through reset is treated as a fresh press and produces exactly one debounced pulse after reset release.

## Timing
- Flags are registered outputs, 0 at reset.
- Press latency: take edge 0 as the first `clk50M` edge that samples `key_n[i]` low, with the input stable. Then `cnt` clears at edge 2 and the flag is high for exactly the cycle after edge `DEBOUNCE_CYC+2`.
- Repeat cadence, with the repeat bit set and the key held: pulse k≥1 follows the accepted-press pulse by `REPEAT_DLY+(k-1)*REPEAT_PER` cycles.
- Release latency: the channel is back in IDLE `DEBOUNCE_CYC+2` edges after the first low-to-high sample. A new press is not recognised before that.
- Counter compares are exact equality; counters never wrap.

## Structure
- Package `key_pkg`: state encoding localparams IDLE=2'd0, DB_PRESS=2'd1, HELD=2'd2, DB_REL=2'd3; default timing constants; the counter-width function.
- Sub-module `key_chan`: synchroniser, state machine, counter and pulse register for one key. It takes parameters `DEBOUNCE_CYC`, `REPEAT_DLY`, `REPEAT_PER` and `RPT`.
- `key_pulse` instantiates `key_chan` 3× in a generate loop, with `RPT=REPEAT_EN[i]`, and maps the outputs to `flg1..3`.

## Test plan
All scenarios use `DEBOUNCE_CYC=4`, `REPEAT_DLY=10`, `REPEAT_PER=3`.
- Clean press of key 0 held 6 cycles, then released → `flg1` high for exactly the single cycle after edge 6; no other pulse; the channel is in IDLE by edge 6 after release.
- Key 1 low for 3 cycles then high (glitch) → no `flg2` pulse. The channel returns to IDLE.
- Key 0 held 40 cycles → `flg1` pulses at press+0, +10, +13, +16, …, +34 relative to the first pulse.
- Key 2 held 40 cycles (`REPEAT_EN[2]=0`) → exactly one `flg3` pulse. Release with a 2-cycle high bounce then low again → no extra pulse.
- Keys 0 and 1 pressed in the same cycle → `flg1` and `flg2` pulse in the same cycle.
- `rst_n` asserted while key 0 is in HELD mid-repeat, then released with the key still held → flags are 0 during reset, then exactly one `flg1` pulse 6 edges after reset release, followed by the normal repeat cadence.
